pipe_skid_reg: RTL and testbench

- Parametrised pipeline-stage register with a ready/valid handshake and a two-entry skid buffer.
- Successor to the fixed-width stall/flush stage registers. Sits between any two pipeline stages.
- Backpressure is registered: upstream never sees a combinational path from out_ready, and full throughput is kept.
- Adds bubble masking of control fields, flush-squash accounting and saturating performance counters.

---
 rtl/pipe_skid_reg.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Purpose : pipeline-stage register with a ready/valid handshake and a two-entry skid buffer.
// Latency : 1 cycle in->out when EMPTY or draining; sustains 1 beat/cycle with out_ready=1.
// Backpr. : in_ready is decoded from the state register only, so out_ready never reaches it combinationally.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset (overrides everything)
//   flush            synchronous squash of all held entries (counters are kept)
//   in_valid/ready   upstream handshake; in_data/in_ctrl are the upstream payload
//   out_valid/ready  downstream handshake; out_data/out_ctrl come from the main slot
//   stall_cnt        saturating count of cycles with out_valid && !out_ready
//   squash_cnt       saturating count of valid beats destroyed by flush
module pipe_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 3,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main invalid, skid invalid
        ST_ONE   = 2'd1,   // main valid,   skid invalid
        ST_FULL  = 2'd2    // main valid,   skid valid
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    state_t            state_d;

    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic              in_xfer;
    logic              out_xfer;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  squash_cnt_q;
    logic              stall_hit;
    logic              main_live;
    logic              skid_live;
    logic [1:0]        squash_n;
    logic [CNT_W+1:0]  squash_sum;
    logic [CNT_W-1:0]  squash_nxt;

    // ------------------------------------------------------------------
    // Handshake decode: both flags come straight from the state register
    // ------------------------------------------------------------------
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_data  = main_data_q;
    // A drained main slot keeps its old control bits, so mask them on a bubble.
    assign out_ctrl  = out_valid ? main_ctrl_q : {CTRL_W{1'b0}};

    // ------------------------------------------------------------------
    // Next-state and slot-load decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        if (flush) begin
            // Any beat accepted this cycle is dropped; nothing is loaded.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new beat behind main.
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_xfer) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Control payload: always cleared on rst/flush
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_ctrl_q <= {CTRL_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
        end else begin
            if (load_main_in) begin
                main_ctrl_q <= in_ctrl;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
                skid_ctrl_q <= in_ctrl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data payload: cleared on rst/flush only when CLEAR_DATA is set,
    // otherwise the slots simply hold across rst/flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if (CLEAR_DATA) begin
                main_data_q <= {DATA_W{1'b0}};
                skid_data_q <= {DATA_W{1'b0}};
            end
        end else begin
            if (load_main_in) begin
                main_data_q <= in_data;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_data_q <= in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    assign stall_hit = out_valid && !out_ready;
    assign main_live = (state_q != ST_EMPTY);
    assign skid_live = (state_q == ST_FULL);

    // A main beat leaving through an output transfer in the flush cycle is
    // delivered, not squashed.
    assign squash_n   = {1'b0, main_live && !out_xfer}
                      + {1'b0, skid_live}
                      + {1'b0, in_xfer};
    // Two spare bits so the addition can never wrap before saturation.
    assign squash_sum = {2'b00, squash_cnt_q} + {{CNT_W{1'b0}}, squash_n};
    assign squash_nxt = (squash_sum > {2'b00, CNT_MAX}) ? CNT_MAX
                                                        : squash_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            squash_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_hit && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                squash_cnt_q <= squash_nxt;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Purpose : directed bench for pipe_skid_reg with a payload scoreboard and counter checks.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : out_ready is driven per step; the scoreboard follows accepted and delivered beats.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  squash_cnt;

    int nvec = 0;
    int nmis = 0;

    // Expected beats as {ctrl, data}, pushed on accepted input, popped on delivery.
    logic [CTRL_W+DATA_W-1:0] sb[$];

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CNT_W     (CNT_W),
        .CLEAR_DATA(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, then step past the posedge.
    task automatic cycle();
        logic [CTRL_W+DATA_W-1:0] exp_beat;
        @(negedge clk);
        if (out_valid && out_ready && !rst) begin
            exp_beat = 'x;
            if (sb.size() != 0) exp_beat = sb.pop_front();
            chk("out_data", {32'd0, out_data}, {32'd0, exp_beat[DATA_W-1:0]});
            chk("out_ctrl", {61'd0, out_ctrl}, {61'd0, exp_beat[CTRL_W+DATA_W-1:DATA_W]});
        end
        if (in_valid && in_ready && !flush && !rst) begin
            sb.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
        if (flush || rst) sb.delete();
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        cycle();
        rst       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",   {63'd0, in_ready}, 64'd1);
        chk("rst_out_ctrl",   {61'd0, out_ctrl}, 64'd0);
        chk("rst_out_data",   {32'd0, out_data}, 64'd0);
        chk("rst_stall_cnt",  {60'd0, stall_cnt}, 64'd0);
        chk("rst_squash_cnt", {60'd0, squash_cnt}, 64'd0);

        // ---------------- streaming ----------------
        in_ctrl   = 3'b101;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h10 + i;
            cycle();
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i == 0) begin
                chk("stream_first_valid", {63'd0, out_valid}, 64'd1);
                chk("stream_first_data",  {32'd0, out_data}, 64'h10);
            end
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_drained",   {63'd0, out_valid}, 64'd0);
        chk("stream_sb_empty",  64'(sb.size()), 64'd0);
        chk("stream_stall_cnt", {60'd0, stall_cnt}, 64'd0);

        // ---------------- backpressure fill ----------------
        do_reset();
        in_ctrl   = 3'b010;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA0;
        cycle();
        chk("bp_one_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_one_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_one_stall", {60'd0, stall_cnt}, 64'd0);
        in_data = 32'hA1;
        cycle();
        chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_full_stall", {60'd0, stall_cnt}, 64'd1);
        in_data = 32'hA2;
        cycle();
        chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_data",  {32'd0, out_data}, 64'hA0);
        chk("bp_hold_stall", {60'd0, stall_cnt}, 64'd2);
        cycle();
        chk("bp_hold2_stall", {60'd0, stall_cnt}, 64'd3);
        out_ready = 1'b1;
        cycle();                       // A0 out, A1 moves to main
        chk("bp_drain_ready", {63'd0, in_ready}, 64'd1);
        cycle();                       // A1 out, A2 accepted
        in_valid = 1'b0;
        for (int k = 0; k < 10 && out_valid; k++) cycle();
        chk("bp_drained",    {63'd0, out_valid}, 64'd0);
        chk("bp_sb_empty",   64'(sb.size()), 64'd0);
        chk("bp_stall_final", {60'd0, stall_cnt}, 64'd3);

        // ---------------- flush in FULL with output transfer ----------------
        do_reset();
        in_ctrl  = 3'b111;
        in_valid = 1'b1;
        in_data  = 32'hB0;
        cycle();
        in_data  = 32'hB1;
        cycle();
        chk("fF_full", {63'd0, in_ready}, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle();                       // B0 delivered, B1 squashed
        flush     = 1'b0;
        chk("fF_squash",    {60'd0, squash_cnt}, 64'd1);
        chk("fF_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fF_out_ctrl",  {61'd0, out_ctrl}, 64'd0);
        chk("fF_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("fF_out_data",  {32'd0, out_data}, 64'd0);
        chk("fF_stall",     {60'd0, stall_cnt}, 64'd1);

        // ---------------- flush in ONE with input transfer ----------------
        do_reset();
        in_ctrl  = 3'b011;
        in_valid = 1'b1;
        in_data  = 32'hC0;
        cycle();
        in_data  = 32'hC1;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("f1_squash",    {60'd0, squash_cnt}, 64'd2);
        chk("f1_out_valid", {63'd0, out_valid}, 64'd0);
        chk("f1_stall",     {60'd0, stall_cnt}, 64'd1);
        cycle();
        chk("f1_stays_empty", {63'd0, out_valid}, 64'd0);

        // ---------------- counter saturation ----------------
        do_reset();
        in_ctrl  = 3'b001;
        in_valid = 1'b1;
        in_data  = 32'hD0;
        cycle();
        in_data  = 32'hD1;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 13) chk("sat_stall_14", {60'd0, stall_cnt}, 64'd14);
        end
        chk("sat_stall_15", {60'd0, stall_cnt}, 64'd15);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("sat_squash_2", {60'd0, squash_cnt}, 64'd2);
        for (int r = 1; r <= 7; r++) begin
            in_valid = 1'b1;
            in_data  = 32'hE0 + 2 * r;
            cycle();
            in_data  = 32'hE1 + 2 * r;
            cycle();
            flush = 1'b1;              // FULL, in_ready low: squash 2
            cycle();
            flush    = 1'b0;
            in_valid = 1'b0;
            if (r == 6) chk("sat_squash_14", {60'd0, squash_cnt}, 64'd14);
        end
        chk("sat_squash_15", {60'd0, squash_cnt}, 64'd15);
        in_valid = 1'b1;
        in_data  = 32'hEE;
        cycle();
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        chk("sat_squash_hold", {60'd0, squash_cnt}, 64'd15);
        chk("sat_stall_hold",  {60'd0, stall_cnt}, 64'd15);

        // ---------------- reset mid-operation ----------------
        in_valid = 1'b1;
        in_data  = 32'hF0;
        cycle();
        in_data  = 32'hF1;
        cycle();
        chk("rm_full", {63'd0, in_ready}, 64'd0);
        rst   = 1'b1;
        flush = 1'b1;
        in_data = 32'hF2;
        cycle();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("rm_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rm_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rm_stall",     {60'd0, stall_cnt}, 64'd0);
        chk("rm_squash",    {60'd0, squash_cnt}, 64'd0);
        chk("rm_out_data",  {32'd0, out_data}, 64'd0);
        chk("rm_out_ctrl",  {61'd0, out_ctrl}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
